// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: instruction-cache, data-cache and main-memory signals.
// slave is the arbiter side; master is the caches/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache block transfers onto one main memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed D priority.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic           clock,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;
  typedef enum logic {REQ_I, REQ_D} req_t;

  state_t state;
  req_t   owner;
  logic   held;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_t   last_grant;
`endif

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Busywait drops only during the release cycle of the requester that owned the transfer.
  assign bus.i_busywait = i_req & ~((state == RELEASE) & (owner == REQ_I));
  assign bus.d_busywait = d_req & ~((state == RELEASE) & (owner == REQ_D));

  always_comb begin
    pick_d = d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req)
      pick_d = (last_grant == REQ_I);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      owner             <= REQ_D;
      held              <= 1'b0;
      bus.i_readdata    <= '0;
      bus.d_readdata    <= '0;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_address   <= '0;
      bus.mem_writedata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant        <= REQ_D;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            held <= 1'b0;
            if (pick_d) begin
              state             <= GRANT_D;
              bus.mem_write     <= bus.d_write;
              bus.mem_read      <= ~bus.d_write;
              bus.mem_address   <= bus.d_address;
              bus.mem_writedata <= bus.d_write ? bus.d_writedata : '0;
            end else begin
              state             <= GRANT_I;
              bus.mem_read      <= 1'b1;
              bus.mem_write     <= 1'b0;
              bus.mem_address   <= bus.i_address;
              bus.mem_writedata <= '0;
            end
          end
        end

        // The grant is held to completion even if the requester withdraws.
        GRANT_I, GRANT_D: begin
          if (!held) begin
            held <= 1'b1;
          end else if (!bus.mem_busywait) begin
            state <= RELEASE;
            owner <= (state == GRANT_D) ? REQ_D : REQ_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= (state == GRANT_D) ? REQ_D : REQ_I;
`endif
            if (state == GRANT_I)
              bus.i_readdata <= bus.mem_readdata;
            else if (bus.mem_read)
              bus.d_readdata <= bus.mem_readdata;
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
          end
        end

        RELEASE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory with programmable latency,
// queues of expected grants and returned blocks checked by negedge monitors.
module tb_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] mem_arr   [0:63];
  logic [DATA_W-1:0] model_mem [0:63];
  logic [DATA_W-1:0] exp_dread;
  int                lat;
  int                cnt;
  bit                lg_model;   // 0 = I served last, 1 = D served last

  logic [DATA_W-1:0] iq[$];
  logic [DATA_W-1:0] dq[$];
  logic [39:0]       gq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int a);
    init_word = (a == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
  endfunction

  assign bus.mem_readdata = mem_arr[bus.mem_address];

  // Memory: busy for lat negedges of an asserted strobe, then ready; writes land when ready.
  initial begin
    cnt = 0;
    for (int a = 0; a < 64; a++) mem_arr[a] = init_word(a);
    bus.mem_busywait = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.mem_read || bus.mem_write) begin
        bus.mem_busywait = (cnt < lat);
        cnt++;
        if (!bus.mem_busywait && bus.mem_write)
          mem_arr[bus.mem_address] = bus.mem_writedata;
      end else begin
        cnt = 0;
        bus.mem_busywait = 1'b1;
      end
    end
  end

  // Grant monitor: every new strobe burst is popped against the expected command.
  logic prev_strobe = 1'b0;
  int   gap = 0;
  bit   gap_valid = 1'b0;
  always @(negedge clock) begin
    logic cur;
    logic [39:0] g;
    cur = bus.mem_read | bus.mem_write;
    if (!reset) gap_valid = 1'b0;
    if (cur && !prev_strobe) begin
      if (gq.size() == 0) begin
        check_eq("grant_unexpected", {bus.mem_read, bus.mem_write, bus.mem_address}, 0);
      end else begin
        g = gq.pop_front();
        check_eq("grant_cmd", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata}, g);
      end
      if (gap_valid) check_eq("strobe_gap_ge2", (gap >= 2) ? 1 : 0, 1);
    end
    if (cur) begin
      gap = 0;
      gap_valid = 1'b1;
    end else begin
      gap++;
    end
    prev_strobe = cur;
  end

  // Completion monitor: busywait low with request high means a block was returned.
  always @(negedge clock) begin
    if (!reset) lg_model = 1'b1;
    if (reset && bus.i_read && !bus.i_busywait) begin
      if (iq.size() == 0) check_eq("i_unexpected", bus.i_readdata, 64'hFFFF_FFFF_FFFF_FFFF);
      else check_eq("i_readdata", bus.i_readdata, iq.pop_front());
      lg_model = 1'b0;
    end
    if (reset && (bus.d_read || bus.d_write) && !bus.d_busywait) begin
      if (dq.size() == 0) check_eq("d_unexpected", bus.d_readdata, 64'hFFFF_FFFF_FFFF_FFFF);
      else check_eq("d_readdata", bus.d_readdata, dq.pop_front());
      lg_model = 1'b1;
    end
  end

  task automatic i_xfer(input logic [ADDR_W-1:0] a, input bit solo);
    int n;
    iq.push_back(model_mem[a]);
    if (solo) gq.push_back({1'b1, 1'b0, a, 32'h0});
    bus.i_read = 1'b1;
    bus.i_address = a;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (solo && n == 2)
        check_eq("i_strobe_latency", {bus.mem_read, bus.mem_address}, {1'b1, a});
    end while (bus.i_busywait && n < 300);
    check_eq("i_done", bus.i_busywait, 1'b0);
    if (solo) check_eq("i_latency", n, (lat == 0) ? 4 : lat + 3);
    @(posedge clock); #1;
    check_eq("i_busywait_one_cycle", bus.i_busywait, 1'b1);
    bus.i_read = 1'b0;
  endtask

  task automatic d_xfer(input logic [ADDR_W-1:0] a, input bit wr, input bit rd,
                        input logic [DATA_W-1:0] wd, input bit solo);
    int n;
    if (wr) begin
      model_mem[a] = wd;
      dq.push_back(exp_dread);
      if (solo) gq.push_back({1'b0, 1'b1, a, wd});
    end else begin
      exp_dread = model_mem[a];
      dq.push_back(exp_dread);
      if (solo) gq.push_back({1'b1, 1'b0, a, 32'h0});
    end
    bus.d_write = wr;
    bus.d_read = rd;
    bus.d_address = a;
    bus.d_writedata = wd;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (solo && n == 2)
        check_eq("d_strobe_latency", {bus.mem_read, bus.mem_write, bus.mem_address}, {~wr, wr, a});
    end while (bus.d_busywait && n < 300);
    check_eq("d_done", bus.d_busywait, 1'b0);
    if (solo) check_eq("d_latency", n, (lat == 0) ? 4 : lat + 3);
    @(posedge clock); #1;
    check_eq("d_busywait_one_cycle", bus.d_busywait, 1'b1);
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic contend(input logic [ADDR_W-1:0] ai, input logic [ADDR_W-1:0] ad);
    bit d_first;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    d_first = (lg_model == 1'b0);
`else
    d_first = 1'b1;
`endif
    if (d_first) begin
      gq.push_back({1'b1, 1'b0, ad, 32'h0});
      gq.push_back({1'b1, 1'b0, ai, 32'h0});
    end else begin
      gq.push_back({1'b1, 1'b0, ai, 32'h0});
      gq.push_back({1'b1, 1'b0, ad, 32'h0});
    end
    fork
      i_xfer(ai, 1'b0);
      d_xfer(ad, 1'b0, 1'b1, 32'h0, 1'b0);
    join
  endtask

  initial begin
    int k;
    for (int a = 0; a < 64; a++) model_mem[a] = init_word(a);
    exp_dread = '0;
    lat = 5;
    bus.i_read = 1'b1;
    bus.i_address = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_address = '0;
    bus.d_writedata = '0;

    // Reset state, with an I request pending to show busywait mirroring.
    #2;
    check_eq("rst_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    check_eq("rst_mem_address", bus.mem_address, 0);
    check_eq("rst_mem_writedata", bus.mem_writedata, 0);
    check_eq("rst_i_readdata", bus.i_readdata, 0);
    check_eq("rst_d_readdata", bus.d_readdata, 0);
    check_eq("rst_busywaits", {bus.i_busywait, bus.d_busywait}, 2'b10);
    bus.i_read = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Uncontended I read with slow memory.
    lat = 5;
    i_xfer(6'h05, 1'b1);

    // D write-back, then read back of the same block.
    d_xfer(6'h12, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1);
    d_xfer(6'h12, 1'b0, 1'b1, 32'h0, 1'b1);

    // Read and write together: write wins.
    lat = 2;
    d_xfer(6'h3F, 1'b1, 1'b1, 32'h5A5A0F0F, 1'b1);

    // Fast memory: completion on the second edge of the grant.
    lat = 0;
    d_xfer(6'h20, 1'b0, 1'b1, 32'h0, 1'b1);
    i_xfer(6'h21, 1'b1);

    // Simultaneous requests, twice.
    lat = 1;
    contend(6'h08, 6'h09);
    contend(6'h0A, 6'h3F);

    // D withdraws its read mid-transfer: transfer still completes and is captured.
    lat = 3;
    gq.push_back({1'b1, 1'b0, 6'h07, 32'h0});
    bus.d_read = 1'b1;
    bus.d_address = 6'h07;
    k = 0;
    do begin @(negedge clock); k++; end while (!bus.mem_read && k < 50);
    #1 bus.d_read = 1'b0;
    @(negedge clock);
    check_eq("abort_grant_held", bus.mem_read, 1'b1);
    k = 0;
    while (bus.mem_read && k < 50) begin @(negedge clock); k++; end
    check_eq("abort_completed", bus.mem_read, 1'b0);
    exp_dread = model_mem[7];
    check_eq("abort_capture", bus.d_readdata, exp_dread);
    @(posedge clock); #1;

    // Reset during a busy D grant abandons the transfer; D is re-granted afterwards.
    reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    exp_dread = '0;
    lat = 5;
    gq.push_back({1'b1, 1'b0, 6'h09, 32'h0});
    gq.push_back({1'b1, 1'b0, 6'h09, 32'h0});
    dq.push_back(model_mem[9]);
    bus.d_read = 1'b1;
    bus.d_address = 6'h09;
    k = 0;
    do begin @(negedge clock); k++; end while (!bus.mem_read && k < 50);
    #1 reset = 1'b0;
    #1;
    check_eq("midrst_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    check_eq("midrst_d_readdata", bus.d_readdata, 0);
    check_eq("midrst_d_busywait", bus.d_busywait, 1'b1);
    @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_eq("midrst_regrant", bus.mem_read, 1'b1);
    k = 0;
    while (bus.d_busywait && k < 300) begin @(negedge clock); k++; end
    check_eq("midrst_done", bus.d_busywait, 1'b0);
    @(posedge clock); #1;
    bus.d_read = 1'b0;
    repeat (3) @(posedge clock);

    check_eq("scoreboard_empty", gq.size() + iq.size() + dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
